mldsa_job_sequencer: RTL
========================

// Module: mldsa_job_sequencer
// PURPOSE
//  Job-level scheduler in front of the MLDSA core's three AXIS channels. Accepts one command
//  (beat counts for A, B and output), steers a single shared upstream AXIS stream first into
//  core port A and then into port B, and gates the core output onto the master AXIS port.
//  On completion it returns a status word. All data paths are combinational; the scheduler
//  itself is only state, counters and checks.
// PARAMETERS
//  DATA_W          64     AXIS data width, all channels
//  LEN_W           16     width of beat-count fields
//  TIMEOUT_CYCLES  65536  stall limit in cycles; used only when MLDSA_SEQ_TIMEOUT_EN is defined
// PORTS
//  clk              in   1       single clock, all logic on the rising edge
//  resetn           in   1       asynchronous, active-low reset
//  cmd_valid        in   1       command present
//  cmd_ready        out  1       command accepted on valid&ready
//  cmd_len_a        in   LEN_W   beats for port A (0 = skip phase)
//  cmd_len_b        in   LEN_W   beats for port B (0 = skip phase)
//  cmd_len_o        in   LEN_W   expected output beats (0 = no length check)
//  s_axis_tdata/tvalid/tlast  in  DATA_W/1/1   shared upstream stream; s_axis_tready out 1
//  MLDSA_data_in_A/i_valid_A/i_last_A  out  DATA_W/1/1   core port A; MLDSA_i_ready_A in 1
//  MLDSA_data_in_B/i_valid_B/i_last_B  out  DATA_W/1/1   core port B; MLDSA_i_ready_B in 1
//  MLDSA_data_out/o_valid/o_last       in   DATA_W/1/1   core result; MLDSA_o_ready out 1
//  m_axis_tdata/tvalid/tlast  out  DATA_W/1/1   result stream; m_axis_tready in 1
//  busy             out  1       state != IDLE
//  sts_valid        out  1       one-cycle pulse at end of job
//  sts_code         out  3       [0] input tlast mismatch, [1] output length mismatch, [2] timeout
// BEHAVIOUR
//  - Reset (async, mid-job included): state=IDLE, beat counter=0, sticky error bits=0, sts_valid=0,
//    sts_code=0. Every valid/ready/last output is decoded from state, so all deassert at once.
//    cmd_ready reads 1 once reset is released.
//  - FSM: IDLE -> FEED_A -> FEED_B -> DRAIN -> DONE -> IDLE.
//    A phase with length 0 is skipped in the same transition; len_a=len_b=0 goes IDLE -> DRAIN.
//  - IDLE: cmd_ready=1. On the cmd handshake, latch all three lengths, clear errors, beat counter=0.
//  - FEED_A: MLDSA_i_valid_A=s_axis_tvalid, s_axis_tready=MLDSA_i_ready_A, data passed through.
//    MLDSA_i_last_A is generated internally as (cnt==len_a-1); upstream tlast is not forwarded.
//  - Input check: s_axis_tlast must differ from the generated last only on a mismatch. Any mismatch
//    sets sts_code[0]; the phase still ends on the final beat count.
//  - FEED_A exit: the final-beat handshake resets cnt and moves to FEED_B (or DRAIN if len_b=0).
//  - FEED_B: same rules, routed to port B. Port-B outputs are low outside FEED_B; same for port A.
//  - DRAIN: m_axis_* = MLDSA_data_out/o_valid/o_last, MLDSA_o_ready=m_axis_tready. cnt counts
//    output handshakes. The phase ends on the o_last handshake. If len_o!=0 and cnt!=len_o-1 at
//    o_last, set sts_code[1].
//  - DONE: held for one cycle with sts_valid=1 and sts_code valid, then IDLE. sts_code holds its
//    value until the next command is accepted.
//  - The counter is LEN_W bits and never wraps within a legal job.
//  - Output beats beyond len_o are passed through; the mismatch is reported only at o_last.
//  - Zero added latency on every data path; backpressure is honoured in both directions.
// CONFIGURATION
//  MLDSA_SEQ_TIMEOUT_EN defined:
//   - A stall counter runs in FEED_A, FEED_B and DRAIN, and clears on any handshake in the
//     active phase.
//   - When it reaches TIMEOUT_CYCLES: set sts_code[2], drop all valid/ready, go to DONE.
//  MLDSA_SEQ_TIMEOUT_EN undefined: no stall counter, sts_code[2] tied 0, a stalled job waits forever.
// TESTING
//  1. len_a=4, len_b=2, len_o=3, no backpressure, tlast correct -> 4 beats on A with i_last_A on
//     beat 4; 2 beats on B; 3 output beats; sts_valid pulse with sts_code=0.
//  2. len_a=0, len_b=3 -> port A never valid; B gets 3 beats. Then len_a=len_b=0 -> straight to
//     DRAIN.
//  3. len_a=4 with upstream tlast on beat 2 -> A still gets 4 beats, i_last_A only on beat 4,
//     sts_code=3'b001.
//  4. len_o=5, core asserts o_last on beat 3; random m_axis_tready -> 3 beats delivered in order,
//     no data lost, sts_code=3'b010.
//  5. resetn low mid-FEED_B -> all valid/ready outputs 0 asynchronously, busy=0 after release, a
//     new cmd is accepted normally.
//  6. MLDSA_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, MLDSA_o_valid held 0 in DRAIN -> sts_valid 17
//     cycles after entry, sts_code=3'b100.

Source files
------------

// File: rtl/mldsa_job_sequencer.sv
// ============================================================================
// mldsa_job_sequencer : job scheduler steering one upstream AXIS stream into
// MLDSA core ports A then B, gating the core result, reporting a status word.
// Optional stall timeout: MLDSA_SEQ_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module mldsa_job_sequencer #(
  parameter int DATA_W         = 64,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len_a,
  input  logic [LEN_W-1:0]  cmd_len_b,
  input  logic [LEN_W-1:0]  cmd_len_o,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] MLDSA_data_in_A,
  output logic              MLDSA_i_valid_A,
  output logic              MLDSA_i_last_A,
  input  logic              MLDSA_i_ready_A,
  output logic [DATA_W-1:0] MLDSA_data_in_B,
  output logic              MLDSA_i_valid_B,
  output logic              MLDSA_i_last_B,
  input  logic              MLDSA_i_ready_B,
  input  logic [DATA_W-1:0] MLDSA_data_out,
  input  logic              MLDSA_o_valid,
  input  logic              MLDSA_o_last,
  output logic              MLDSA_o_ready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              sts_valid,
  output logic [2:0]        sts_code
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FEED_A = 3'd1,
    S_FEED_B = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_cnt, w_cnt_next;
  logic [LEN_W-1:0] r_len_a, r_len_b, r_len_o;
  logic [2:0]       r_err, w_err_next;
  logic             w_cmd_hs, w_hs_a, w_hs_b, w_hs_o, w_last_a, w_last_b;
  logic             w_timeout;

  assign w_cmd_hs = (r_state == S_IDLE) && cmd_valid && resetn;
  assign w_last_a = (r_cnt == r_len_a - LEN_W'(1));
  assign w_last_b = (r_cnt == r_len_b - LEN_W'(1));
  assign w_hs_a   = (r_state == S_FEED_A) && s_axis_tvalid && MLDSA_i_ready_A && !w_timeout;
  assign w_hs_b   = (r_state == S_FEED_B) && s_axis_tvalid && MLDSA_i_ready_B && !w_timeout;
  assign w_hs_o   = (r_state == S_DRAIN) && MLDSA_o_valid && m_axis_tready && !w_timeout;

`ifdef MLDSA_SEQ_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] r_stall;
  logic               w_active;

  assign w_active  = (r_state == S_FEED_A) || (r_state == S_FEED_B) || (r_state == S_DRAIN);
  assign w_timeout = (r_stall == STALL_W'(TIMEOUT_CYCLES));

  // Any handshake in the active phase restarts the stall window
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_stall <= '0;
    else if (!w_active || w_hs_a || w_hs_b || w_hs_o || w_timeout)
      r_stall <= '0;
    else
      r_stall <= r_stall + STALL_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next          = r_state;
    w_cnt_next      = r_cnt;
    w_err_next      = r_err;
    cmd_ready       = 1'b0;
    s_axis_tready   = 1'b0;
    MLDSA_data_in_A = '0;
    MLDSA_i_valid_A = 1'b0;
    MLDSA_i_last_A  = 1'b0;
    MLDSA_data_in_B = '0;
    MLDSA_i_valid_B = 1'b0;
    MLDSA_i_last_B  = 1'b0;
    MLDSA_o_ready   = 1'b0;
    m_axis_tdata    = '0;
    m_axis_tvalid   = 1'b0;
    m_axis_tlast    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = resetn;
        if (w_cmd_hs) begin
          w_err_next = 3'b000;
          w_cnt_next = '0;
          if (cmd_len_a != '0)      w_next = S_FEED_A;
          else if (cmd_len_b != '0) w_next = S_FEED_B;
          else                      w_next = S_DRAIN;
        end
      end
      S_FEED_A: if (!w_timeout) begin
        MLDSA_data_in_A = s_axis_tdata;
        MLDSA_i_valid_A = s_axis_tvalid;
        MLDSA_i_last_A  = w_last_a;
        s_axis_tready   = MLDSA_i_ready_A;
        if (w_hs_a) begin
          if (s_axis_tlast != w_last_a) w_err_next[0] = 1'b1;
          if (w_last_a) begin
            w_cnt_next = '0;
            w_next     = (r_len_b != '0) ? S_FEED_B : S_DRAIN;
          end else begin
            w_cnt_next = r_cnt + LEN_W'(1);
          end
        end
      end
      S_FEED_B: if (!w_timeout) begin
        MLDSA_data_in_B = s_axis_tdata;
        MLDSA_i_valid_B = s_axis_tvalid;
        MLDSA_i_last_B  = w_last_b;
        s_axis_tready   = MLDSA_i_ready_B;
        if (w_hs_b) begin
          if (s_axis_tlast != w_last_b) w_err_next[0] = 1'b1;
          if (w_last_b) begin
            w_cnt_next = '0;
            w_next     = S_DRAIN;
          end else begin
            w_cnt_next = r_cnt + LEN_W'(1);
          end
        end
      end
      S_DRAIN: if (!w_timeout) begin
        m_axis_tdata  = MLDSA_data_out;
        m_axis_tvalid = MLDSA_o_valid;
        m_axis_tlast  = MLDSA_o_last;
        MLDSA_o_ready = m_axis_tready;
        // Surplus beats pass through; length is judged only at o_last
        if (w_hs_o) begin
          if (MLDSA_o_last) begin
            if ((r_len_o != '0) && (r_cnt != r_len_o - LEN_W'(1))) w_err_next[1] = 1'b1;
            w_cnt_next = '0;
            w_next     = S_DONE;
          end else begin
            w_cnt_next = r_cnt + LEN_W'(1);
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_err_next[2] = 1'b1;
      w_cnt_next    = '0;
      w_next        = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 3'b000;
      r_len_a <= '0;
      r_len_b <= '0;
      r_len_o <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      if (w_cmd_hs) begin
        r_len_a <= cmd_len_a;
        r_len_b <= cmd_len_b;
        r_len_o <= cmd_len_o;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign sts_valid = (r_state == S_DONE);
  assign sts_code  = r_err;

endmodule

`default_nettype wire
